// File: rtl/mem_arb_pkg.sv
// Shared types and the round-robin pick helper for the DDR4 port arbiter.
// rr_pick scans a fixed-width vector so one function serves every NumReq up to MaxReq.
package mem_arb_pkg;

  localparam int unsigned NumReqDef = 4;
  localparam int unsigned MaxReq    = 32;
  localparam int unsigned MaxReqW   = $clog2(MaxReq);

  typedef logic [$clog2(NumReqDef)-1:0] req_idx_t;

  typedef enum logic {
    ARB,
    LOCKED
  } arb_state_e;

  // First requester at or after ptr, wrapping modulo numReq; found=0 when none.
  function automatic int unsigned rr_pick(input logic [MaxReq-1:0] req,
                                          input int unsigned       ptr,
                                          input int unsigned       numReq,
                                          output logic             found);
    int unsigned idx;
    rr_pick = 0;
    found   = 1'b0;
    for (int unsigned k = 0; k < MaxReq; k++) begin
      idx = ptr + k;
      if (idx >= numReq) idx = idx - numReq;
      if (k < numReq && !found && req[idx[MaxReqW-1:0]]) begin
        found   = 1'b1;
        rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order FIFO of requester indices for outstanding memory transfers.
// The storage array is not reset; only pointers and count are.
module mem_arb_id_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [Width-1:0]             wdata_i,
  output logic [Width-1:0]             head_o,
  output logic [$clog2(Depth+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             doPush, doPop;

  function automatic logic [PtrW-1:0] incPtr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign doPush  = push_i & ~full_o;
  assign doPop   = pop_i & ~empty_o;
  assign head_o  = mem_q[rdPtr_q];
  assign count_o = count_q;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = incPtr(wrPtr_q);
    if (doPop)  rdPtr_d = incPtr(rdPtr_q);
    case ({doPush, doPop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing the DDR4 front-end port between NumReq core ports.
// A presented request is locked until granted; responses return via an in-order ID FIFO.
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                 clk_sys_i,
  input  logic                                 rst_sys_ni,
  input  logic [NumReq-1:0]                    req_i,
  output logic [NumReq-1:0]                    gnt_o,
  input  logic [NumReq-1:0]                    we_i,
  input  logic [NumReq-1:0][DataWidth/8-1:0]   be_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]     addr_i,
  input  logic [NumReq-1:0][DataWidth-1:0]     wdata_i,
  output logic [NumReq-1:0]                    rvalid_o,
  output logic [DataWidth-1:0]                 rdata_o,
  output logic                                 mem_req_o,
  input  logic                                 mem_gnt_i,
  output logic                                 mem_we_o,
  output logic [DataWidth/8-1:0]               mem_be_o,
  output logic [AddrWidth-1:0]                 mem_addr_o,
  output logic [DataWidth-1:0]                 mem_wdata_o,
  input  logic                                 mem_rvalid_i,
  input  logic [DataWidth-1:0]                 mem_rdata_i,
  output logic                                 err_o
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  typedef logic [IdxW-1:0] idx_t;

  arb_state_e        state_q, state_d;
  idx_t              ptr_q, ptr_d, lockIdx_q, lockIdx_d;
  logic              err_q, err_d;
  idx_t              winner, fifoHead;
  logic              winValid, grant, pop;
  logic              fifoFull, fifoEmpty;
  logic [CntW-1:0]   fifoCount;
  logic [MaxReq-1:0] reqExt;
  int unsigned       pick;
  logic              pickFound;

  assign reqExt = MaxReq'(req_i);

  // A locked request keeps the port even if a higher-priority requester shows up.
  always_comb begin
    pick   = rr_pick(reqExt, 32'(ptr_q), NumReq, pickFound);
    winner = idx_t'(pick);
    winValid = pickFound;
    if (state_q == LOCKED) begin
      winner   = lockIdx_q;
      winValid = req_i[lockIdx_q];
    end
  end

  // Gated by reset so the port is quiet while the block is held in reset.
  assign mem_req_o   = rst_sys_ni & winValid & ~fifoFull;
  assign grant       = mem_req_o & mem_gnt_i;
  assign pop         = mem_rvalid_i & ~fifoEmpty;
  assign mem_we_o    = we_i[winner];
  assign mem_be_o    = be_i[winner];
  assign mem_addr_o  = addr_i[winner];
  assign mem_wdata_o = wdata_i[winner];
  assign rdata_o     = mem_rdata_i;
  assign err_o       = err_q;

  always_comb begin
    gnt_o = '0;
    if (grant) gnt_o[winner] = 1'b1;
  end

  always_comb begin
    rvalid_o = '0;
    if (mem_rvalid_i && fifoCount != '0) rvalid_o[fifoHead] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    lockIdx_d = lockIdx_q;
    err_d     = err_q;
    if (mem_rvalid_i && fifoEmpty) err_d = 1'b1;
    unique case (state_q)
      ARB: begin
        if (mem_req_o && !mem_gnt_i) begin
          state_d   = LOCKED;
          lockIdx_d = winner;
        end
      end
      LOCKED: begin
        if (!req_i[lockIdx_q]) begin
          state_d = ARB;
          err_d   = 1'b1;
        end else if (grant) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
    if (grant) ptr_d = (winner == idx_t'(NumReq - 1)) ? '0 : winner + idx_t'(1);
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      state_q   <= ARB;
      ptr_q     <= '0;
      lockIdx_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      lockIdx_q <= lockIdx_d;
      err_q     <= err_d;
    end
  end

  mem_arb_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdxW)
  ) u_id_fifo (
    .clk_i   (clk_sys_i),
    .rst_ni  (rst_sys_ni),
    .push_i  (grant),
    .pop_i   (pop),
    .wdata_i (winner),
    .head_o  (fifoHead),
    .count_o (fifoCount),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

endmodule
